// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-line object scan, pattern fetch and draw into a double-buffered line
module sprite_line_engine #(
    parameter int NUM_OBJECTS  = 64,
    parameter int OBJ_SIZE     = 8,
    parameter int MAX_PER_LINE = 16,
    parameter int LINE_WIDTH   = 256,
    parameter int VISIBLE_ROWS = 240,
    localparam int AW = $clog2(NUM_OBJECTS),
    localparam int RW = $clog2(OBJ_SIZE),
    localparam int PW = 5 + RW
) (
    input  logic                  gpu_clk,
    input  logic                  rst,
    input  logic                  line_start_i,
    input  logic [8:0]            row_i,
    input  logic                  swap_i,
    input  logic [8:0]            current_x_i,
    output logic [AW-1:0]         obm_addr_o,
    input  logic [31:0]           obm_data_i,
    output logic [PW-1:0]         pmf_addr_o,
    input  logic [2*OBJ_SIZE-1:0] pmf_data_i,
    output logic [1:0]            r_o,
    output logic [1:0]            g_o,
    output logic [1:0]            b_o,
    output logic                  valid_o,
    output logic                  busy_o,
    output logic                  overflow_o,
    output logic                  late_o
);
    localparam int HW = $clog2(MAX_PER_LINE + 1);
    localparam int KW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
    localparam int XW = $clog2(LINE_WIDTH);
    localparam int DW = 2 * OBJ_SIZE;
    localparam logic [9:0] LW10 = 10'(LINE_WIDTH);
    localparam logic [8:0] VR9  = 9'(VISIBLE_ROWS);
    localparam logic [8:0] OS9  = 9'(OBJ_SIZE);

    typedef enum logic [2:0] {IDLE, SCAN, FETCH_A, FETCH_B, DRAW} state_t;

    state_t          r_state, w_next;
    logic [8:0]      r_row;
    logic [AW:0]     r_cnt;
    logic [HW-1:0]   r_hits;
    logic [KW-1:0]   r_k;
    logic [RW-1:0]   r_px;
    logic [DW-1:0]   r_pat;
    logic            r_sel, r_ovf, r_late;
    logic [7:0]      r_lx    [MAX_PER_LINE];
    logic [RW-1:0]   r_lrow  [MAX_PER_LINE];
    logic            r_lhf   [MAX_PER_LINE];
    logic [4:0]      r_lpmfa [MAX_PER_LINE];
    logic [2:0]      r_lcol  [MAX_PER_LINE];
    logic [4:0]      r_buf   [2][LINE_WIDTH];

    logic            w_busy, w_hit, w_full, w_push, w_scan_end, w_last_px, w_last_k;
    logic            w_back, w_clr_sel, w_in, w_we, w_unused;
    logic [8:0]      w_dy, w_tgt;
    logic [RW-1:0]   w_prow;
    logic [XW-1:0]   w_tidx;
    logic [1:0]      w_shade;
    logic [DW-1:0]   w_rev;
    logic [4:0]      w_front;

    assign w_busy     = r_state != IDLE;
    assign w_dy       = r_row - {1'b0, obm_data_i[23:16]};
    assign w_hit      = r_state == SCAN && r_cnt != '0 && r_row < VR9 && w_dy < OS9;
    assign w_full     = r_hits == HW'(MAX_PER_LINE);
    assign w_push     = w_hit && !w_full;
    assign w_scan_end = r_cnt == (AW+1)'(NUM_OBJECTS);
    assign w_prow     = obm_data_i[13] ? ~w_dy[RW-1:0] : w_dy[RW-1:0];
    assign w_last_px  = r_px == RW'(OBJ_SIZE - 1);
    assign w_last_k   = HW'(r_k) + HW'(1) == r_hits;
    assign w_shade    = r_pat[DW-1 -: 2];
    assign w_tgt      = {1'b0, r_lx[r_k]} + 9'(r_px);
    assign w_in       = {1'b0, w_tgt} < LW10;
    assign w_tidx     = w_tgt[XW-1:0];
    assign w_back     = ~r_sel;
    // A simultaneous swap makes the current front the buffer that gets rebuilt
    assign w_clr_sel  = swap_i ? r_sel : ~r_sel;
    assign w_we       = r_state == DRAW && !swap_i && !line_start_i && w_in && w_shade != 2'd0
                        && r_buf[w_back][w_tidx][4:3] == 2'd0;
    assign w_front    = ({1'b0, current_x_i} < LW10) ? r_buf[r_sel][current_x_i[XW-1:0]] : 5'd0;
    assign w_unused   = ^{obm_data_i[15], obm_data_i[7:3]};

    assign obm_addr_o = r_cnt[AW-1:0];
    assign pmf_addr_o = {r_lpmfa[r_k], r_lrow[r_k]};
    assign r_o        = w_front[4:3] & {2{w_front[2]}};
    assign g_o        = w_front[4:3] & {2{w_front[1]}};
    assign b_o        = w_front[4:3] & {2{w_front[0]}};
    assign valid_o    = w_front[4:3] != 2'd0;
    assign busy_o     = w_busy;
    assign overflow_o = r_ovf;
    assign late_o     = r_late;

    // Pixel-order reversal of the fetched pattern row for horizontal flip
    always_comb begin
        w_rev = '0;
        for (int j = 0; j < OBJ_SIZE; j++) w_rev[2*j +: 2] = pmf_data_i[2*(OBJ_SIZE-1-j) +: 2];
    end

    // Next state: line start restarts, swap aborts, otherwise scan/fetch/draw sequencing
    always_comb begin
        w_next = r_state;
        if (line_start_i) w_next = SCAN;
        else if (swap_i) w_next = IDLE;
        else begin
            case (r_state)
                SCAN:    if (w_scan_end) w_next = (r_hits != '0 || w_push) ? FETCH_A : IDLE;
                FETCH_A: w_next = FETCH_B;
                FETCH_B: w_next = DRAW;
                DRAW:    if (w_last_px) w_next = w_last_k ? IDLE : FETCH_A;
                default: w_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge gpu_clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // Scan counters, hit list, pattern shifter, buffer select and status flags
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            r_row  <= '0;
            r_cnt  <= '0;
            r_hits <= '0;
            r_k    <= '0;
            r_px   <= '0;
            r_pat  <= '0;
            r_sel  <= 1'b0;
            r_ovf  <= 1'b0;
            r_late <= 1'b0;
            for (int j = 0; j < MAX_PER_LINE; j++) begin
                r_lx[j]    <= '0;
                r_lrow[j]  <= '0;
                r_lhf[j]   <= 1'b0;
                r_lpmfa[j] <= '0;
                r_lcol[j]  <= '0;
            end
        end else begin
            r_late <= swap_i && w_busy;
            if (swap_i) r_sel <= ~r_sel;
            if (line_start_i) begin
                r_row  <= row_i;
                r_cnt  <= '0;
                r_hits <= '0;
                r_k    <= '0;
                r_ovf  <= 1'b0;
            end else if (!swap_i) begin
                if (r_state == SCAN && !w_scan_end) r_cnt <= r_cnt + 1'b1;
                if (w_push) begin
                    r_lx[r_hits[KW-1:0]]    <= obm_data_i[31:24];
                    r_lrow[r_hits[KW-1:0]]  <= w_prow;
                    r_lhf[r_hits[KW-1:0]]   <= obm_data_i[14];
                    r_lpmfa[r_hits[KW-1:0]] <= obm_data_i[12:8];
                    r_lcol[r_hits[KW-1:0]]  <= obm_data_i[2:0];
                    r_hits                  <= r_hits + 1'b1;
                end
                if (w_hit && w_full) r_ovf <= 1'b1;
                if (r_state == FETCH_B) begin
                    r_pat <= r_lhf[r_k] ? w_rev : pmf_data_i;
                    r_px  <= '0;
                end
                if (r_state == DRAW) begin
                    r_pat <= r_pat << 2;
                    r_px  <= r_px + 1'b1;
                    if (w_last_px && !w_last_k) r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Line buffers: full clear of the build target on line start, one draw write per cycle
    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++)
                for (int j = 0; j < LINE_WIDTH; j++) r_buf[s][j] <= 5'd0;
        end else if (line_start_i) begin
            for (int j = 0; j < LINE_WIDTH; j++) r_buf[w_clr_sel][j] <= 5'd0;
        end else if (w_we) begin
            r_buf[w_back][w_tidx] <= {w_shade, r_lcol[r_k]};
        end
    end
endmodule
